// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the padder state encoding.
package sha256_pkg;

    localparam int BLOCK_W     = 512;
    localparam int LEN_W       = 64;
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int LEN_OFS     = (BLOCK_W - LEN_W) / 8;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        COLLECT,
        OUT_DATA,
        PAD,
        OUT_PAD1,
        LEN,
        OUT_FINAL
    } padder_state_t;

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream front end of the SHA-256 core: packs bytes big-endian into
// 512-bit blocks and appends the 0x80 / zero-fill / 64-bit length padding.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLOCK_W-1:0] blk_data,
    output logic [LEN_W-1:0]   bitlen
);

    padder_state_t      state;
    logic [6:0]         idx;
    logic               in_msg;
    logic [BLOCK_W-1:0] buffer;
    logic [BLOCK_W-1:0] collect_buf;
    logic [BLOCK_W-1:0] pad_buf;
    logic [BLOCK_W-1:0] len_buf;
    logic               accept;

    assign in_ready = (state == COLLECT);
    assign accept   = in_valid && in_ready;
    assign blk_data = buffer;

    // The first byte of a message starts from an all-zero buffer; later bytes
    // overlay onto whatever has been collected so far.
    for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_lane
        localparam int HI = BLOCK_W - 1 - 8 * k;

        assign collect_buf[HI -: 8] = (idx == 7'(k)) ? in_data
                                    : (in_msg ? buffer[HI -: 8] : 8'h00);

        if (k < LEN_OFS) begin : g_data
            assign pad_buf[HI -: 8] = (idx == 7'(k)) ? PAD_BYTE : buffer[HI -: 8];
        end else begin : g_len
            localparam int LHI = LEN_W - 1 - 8 * (k - LEN_OFS);
            assign pad_buf[HI -: 8] = (idx <= 7'(LEN_OFS - 1)) ? bitlen[LHI -: 8]
                                    : ((idx == 7'(k)) ? PAD_BYTE : buffer[HI -: 8]);
        end
    end

    // A message ending exactly on a block boundary still owes the 0x80 marker.
    assign len_buf = {(idx == 7'(BLOCK_BYTES)) ? PAD_BYTE : 8'h00,
                      {(BLOCK_W - LEN_W - 8){1'b0}},
                      bitlen};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            idx       <= '0;
            in_msg    <= 1'b0;
            buffer    <= '0;
            bitlen    <= '0;
            blk_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        buffer <= collect_buf;
                        idx    <= idx + 7'd1;
                        bitlen <= in_msg ? bitlen + 64'd8 : 64'd8;
                        in_msg <= !in_last;
                        if (in_last) begin
                            state <= PAD;
                        end else if (idx == 7'(BLOCK_BYTES - 1)) begin
                            state     <= OUT_DATA;
                            blk_valid <= 1'b1;
                        end
                    end
                end
                OUT_DATA: begin
                    if (blk_ready) begin
                        buffer    <= '0;
                        idx       <= '0;
                        blk_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                PAD: begin
                    buffer    <= pad_buf;
                    blk_valid <= 1'b1;
                    state     <= (idx <= 7'(LEN_OFS - 1)) ? OUT_FINAL : OUT_PAD1;
                end
                OUT_PAD1: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        state     <= LEN;
                    end
                end
                LEN: begin
                    buffer    <= len_buf;
                    blk_valid <= 1'b1;
                    state     <= OUT_FINAL;
                end
                OUT_FINAL: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        idx       <= '0;
                        state     <= COLLECT;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    blk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed FIPS padding cases, a length
// table, stall and reset sequences, and random messages against a padding model.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic [63:0]  bitlen;

    int total = 0;
    int bad   = 0;

    localparam logic [511:0] ABC_BLK = {24'h616263, 8'h80, 416'h0, 64'h18};

    typedef struct {
        int          len;
        int          mode;
        int          exp_blocks;
        logic [63:0] exp_bits;
    } vec_t;

    sha256_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .bitlen    (bitlen)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Padding model: message, 0x80, zeros up to 56 mod 64, then 64-bit bit count.
    function automatic void buildExpected(input logic [7:0] msg[$], output logic [511:0] blks[$]);
        logic [7:0]   q[$];
        logic [63:0]  bits;
        logic [511:0] b;
        q = msg;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) q.push_back(bits[63 - 8 * i -: 8]);
        blks = {};
        for (int n = 0; n < q.size() / 64; n++) begin
            for (int k = 0; k < 64; k++) b[511 - 8 * k -: 8] = q[64 * n + k];
            blks.push_back(b);
        end
    endfunction

    function automatic void makeMessage(input int len, input int mode, output logic [7:0] msg[$]);
        msg = {};
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       msg.push_back(8'(i));
                1:       msg.push_back(8'hFF);
                2:       msg.push_back(8'h00);
                default: msg.push_back(8'($urandom));
            endcase
        end
    endfunction

    // Drives one message and collects blocks; must be entered #1 after a rising edge.
    task automatic applyStimulus(input logic [7:0] msg[$], input int exp_n, input int vpct,
                                 input int rpct, output logic [511:0] got[$]);
        int sent = 0;
        int cycles = 0;
        got = {};
        while (!(sent == msg.size() && got.size() == exp_n)) begin
            if (cycles > 3000) begin
                total++;
                bad++;
                $display("[TB] FAIL timeout: sent %0d of %0d bytes, got %0d of %0d blocks",
                         sent, msg.size(), got.size(), exp_n);
                break;
            end
            in_valid  = (sent < msg.size()) && ($urandom_range(99) < vpct);
            in_data   = in_valid ? msg[sent] : 8'($urandom);
            in_last   = in_valid && (sent == msg.size() - 1);
            blk_ready = ($urandom_range(99) < rpct);
            if (in_valid && in_ready) sent++;
            if (blk_valid && blk_ready) got.push_back(blk_data);
            @(posedge clk); #1;
            cycles++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b0;
    endtask

    task automatic runCase(input string name, input logic [7:0] msg[$], input int vpct,
                           input int rpct, output logic [511:0] got[$]);
        logic [511:0] exp[$];
        buildExpected(msg, exp);
        applyStimulus(msg, exp.size(), vpct, rpct, got);
        checkOutput({name, "_count"}, 512'(got.size()), 512'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) checkOutput({name, "_blk"}, got[i], exp[i]);
        checkOutput({name, "_bitlen"}, 512'(bitlen), 512'(64'(msg.size()) * 64'd8));
        repeat (2) @(posedge clk);
        #1;
        checkOutput({name, "_idle_valid"}, 512'(blk_valid), 512'(0));
        checkOutput({name, "_idle_ready"}, 512'(in_ready), 512'(1));
    endtask

    initial begin
        logic [7:0]   msg[$];
        logic [511:0] got[$];
        logic [511:0] inc_blk;
        logic [511:0] held;
        logic [7:0]   abc_b[3];
        vec_t         tbl[10];
        int           waited;
        int           extra;

        abc_b = '{8'h61, 8'h62, 8'h63};
        tbl[0] = '{1,   0, 1, 64'd8};
        tbl[1] = '{3,   3, 1, 64'd24};
        tbl[2] = '{55,  0, 1, 64'h1B8};
        tbl[3] = '{56,  0, 2, 64'h1C0};
        tbl[4] = '{63,  3, 2, 64'd504};
        tbl[5] = '{64,  3, 2, 64'h200};
        tbl[6] = '{65,  0, 2, 64'd520};
        tbl[7] = '{119, 3, 2, 64'd952};
        tbl[8] = '{120, 3, 3, 64'd960};
        tbl[9] = '{128, 0, 3, 64'd1024};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 512'(blk_valid), 512'(0));
        checkOutput("rst_data", blk_data, 512'(0));
        checkOutput("rst_bitlen", 512'(bitlen), 512'(0));
        checkOutput("rst_ready", 512'(in_ready), 512'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed padding cases");
        msg = {8'h61, 8'h62, 8'h63};
        runCase("abc", msg, 100, 100, got);
        checkOutput("abc_literal", got[0], ABC_BLK);

        makeMessage(55, 2, msg);
        runCase("zero55", msg, 100, 100, got);
        checkOutput("zero55_literal", got[0], {440'h0, 8'h80, 64'h1B8});

        makeMessage(56, 1, msg);
        runCase("ff56", msg, 100, 100, got);
        checkOutput("ff56_literal0", got[0], {{56{8'hFF}}, 8'h80, 56'h0});
        checkOutput("ff56_literal1", got[1], {448'h0, 64'h1C0});

        makeMessage(64, 0, msg);
        for (int k = 0; k < 64; k++) inc_blk[511 - 8 * k -: 8] = 8'(k);
        runCase("inc64", msg, 100, 100, got);
        checkOutput("inc64_literal0", got[0], inc_blk);
        checkOutput("inc64_literal1", got[1], {8'h80, 440'h0, 64'h200});

        $display("[TB] length table");
        for (int i = 0; i < 10; i++) begin
            makeMessage(tbl[i].len, tbl[i].mode, msg);
            runCase("tbl", msg, 70, 60, got);
            checkOutput("tbl_blocks", 512'(got.size()), 512'(tbl[i].exp_blocks));
            checkOutput("tbl_bits", 512'(bitlen), 512'(tbl[i].exp_bits));
        end

        $display("[TB] backpressure hold");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = abc_b[i];
            in_last  = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        waited = 0;
        while (!blk_valid && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("stall_appear", 512'(blk_valid), 512'(1));
        held = blk_data;
        checkOutput("stall_blk", held, ABC_BLK);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            in_last  = 1'b1;
            @(posedge clk); #1;
            checkOutput("stall_valid", 512'(blk_valid), 512'(1));
            checkOutput("stall_data", blk_data, held);
            checkOutput("stall_ready", 512'(in_ready), 512'(0));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        @(posedge clk); #1;
        blk_ready = 1'b0;
        checkOutput("release_valid", 512'(blk_valid), 512'(0));
        checkOutput("release_ready", 512'(in_ready), 512'(1));
        checkOutput("release_bitlen", 512'(bitlen), 512'(24));
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (blk_valid) extra++;
        end
        checkOutput("release_single", 512'(extra), 512'(0));

        $display("[TB] reset mid-message");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 + 8'(i);
            in_last  = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("abort_valid", 512'(blk_valid), 512'(0));
        checkOutput("abort_data", blk_data, 512'(0));
        checkOutput("abort_bitlen", 512'(bitlen), 512'(0));
        checkOutput("abort_ready", 512'(in_ready), 512'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        msg = {8'h61, 8'h62, 8'h63};
        runCase("post_rst", msg, 100, 100, got);
        checkOutput("post_rst_literal", got[0], ABC_BLK);

        $display("[TB] random messages");
        for (int r = 0; r < 15; r++) begin
            makeMessage($urandom_range(140, 1), 3, msg);
            runCase("rand", msg, $urandom_range(100, 30), $urandom_range(100, 20), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
